// File: rtl/hit_acc_frame_if.sv
// rtl/hit_acc_frame_if.sv - hit beat input stream and candidate output stream of hit_acc_frame
//
// Signals:
//   hit_valid / hit / hit_ready       : hit beat stream into the accumulator
//   candidate / cand_valid / cand_ready : per-frame result stream out of the accumulator
// Modports:
//   slave  : accumulator side (consumes hits, produces candidates)
//   master : producer/consumer side (drives hits, accepts candidates)
interface hit_acc_frame_if #(
    parameter int HIT_W = 16,
    parameter int CNT_W = 16
);
    logic             hit_valid;
    logic [HIT_W-1:0] hit;
    logic             hit_ready;
    logic [CNT_W-1:0] candidate;
    logic             cand_valid;
    logic             cand_ready;

    modport slave (
        input  hit_valid, hit, cand_ready,
        output hit_ready, candidate, cand_valid
    );

    modport master (
        output hit_valid, hit, cand_ready,
        input  hit_ready, candidate, cand_valid
    );
endinterface

// File: rtl/hit_acc_frame.sv
// rtl/hit_acc_frame.sv - framed popcount accumulator producing one candidate count per frame
//
// Optional feature macro: HIT_ACC_SAT_EN
//   defined   : running sum saturates at all-ones instead of wrapping
//   undefined : running sum wraps modulo 2^CNT_W
//
// Ports:
//   clk       in   clock, all state on rising edge
//   rst       in   asynchronous reset, active-low
//   start     in   frame start request, honoured only in IDLE
//   frame_len in   beats per frame, sampled with an accepted start
//   busy      out  high in ACC or HOLD
//   overflow  out  sticky carry-out-of-CNT_W flag for the current frame
//   bus       if   slave modport: hit stream in, candidate stream out
module hit_acc_frame #(
    parameter int HIT_W = 16,
    parameter int CNT_W = 16,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    output logic              busy,
    output logic              overflow,
    hit_acc_frame_if.slave    bus
);
    localparam int PC_W = $clog2(HIT_W + 1);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_q;
    logic [CNT_W-1:0] sum_q;
    logic [CNT_W-1:0] cand_q;
    logic             cand_valid_q;
    logic             hit_ready_q;
    logic             busy_q;
    logic             ovf_q;

    logic [PC_W-1:0]  pc;
    logic [CNT_W:0]   add_w;
    logic             carry;
    logic [CNT_W-1:0] sum_d;
    logic             beat_acc;
    logic             last_beat;

    function automatic logic [PC_W-1:0] popcount(input logic [HIT_W-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < HIT_W; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    always_comb begin
        pc    = popcount(bus.hit);
        // One extra bit on the adder exposes the carry out of CNT_W.
        add_w = {1'b0, sum_q} + (CNT_W + 1)'(pc);
        carry = add_w[CNT_W];
`ifdef HIT_ACC_SAT_EN
        // Once saturated every further add carries again, so the sum stays pinned.
        sum_d = carry ? {CNT_W{1'b1}} : add_w[CNT_W-1:0];
`else
        sum_d = add_w[CNT_W-1:0];
`endif
        // hit_ready_q is only ever high in ACC, so it doubles as the state qualifier.
        beat_acc  = bus.hit_valid & hit_ready_q;
        last_beat = beat_acc && (beat_q == (len_q - LEN_W'(1)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            beat_q       <= '0;
            sum_q        <= '0;
            cand_q       <= '0;
            cand_valid_q <= 1'b0;
            hit_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (frame_len != '0) begin
                            len_q       <= frame_len;
                            sum_q       <= '0;
                            beat_q      <= '0;
                            hit_ready_q <= 1'b1;
                            state_q     <= ACC;
                        end else begin
                            // Empty frame: report a zero candidate without touching the hit stream.
                            cand_q       <= '0;
                            cand_valid_q <= 1'b1;
                            state_q      <= HOLD;
                        end
                    end
                end
                ACC: begin
                    if (beat_acc) begin
                        ovf_q <= ovf_q | carry;
                        if (last_beat) begin
                            cand_q       <= sum_d;
                            cand_valid_q <= 1'b1;
                            hit_ready_q  <= 1'b0;
                            state_q      <= HOLD;
                        end else begin
                            sum_q  <= sum_d;
                            beat_q <= beat_q + LEN_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // start is deliberately not looked at here, even on the exit cycle.
                    if (bus.cand_ready) begin
                        cand_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    cand_valid_q <= 1'b0;
                    hit_ready_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hit_ready  = hit_ready_q;
    assign bus.candidate  = cand_q;
    assign bus.cand_valid = cand_valid_q;
    assign busy           = busy_q;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_hit_acc_frame.sv
// tb/tb_hit_acc_frame.sv - directed scoreboard bench for hit_acc_frame
module tb_hit_acc_frame;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: default widths
    logic        start_a = 1'b0;
    logic [7:0]  len_a   = '0;
    logic        busy_a;
    logic        ovf_a;
    hit_acc_frame_if #(.HIT_W(16), .CNT_W(16)) a_if ();

    hit_acc_frame #(.HIT_W(16), .CNT_W(16), .LEN_W(8)) u_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start_a),
        .frame_len (len_a),
        .busy      (busy_a),
        .overflow  (ovf_a),
        .bus       (a_if.slave)
    );

    // Instance B: narrow 5-bit sum for overflow behaviour
    logic        start_b = 1'b0;
    logic [7:0]  len_b   = '0;
    logic        busy_b;
    logic        ovf_b;
    hit_acc_frame_if #(.HIT_W(16), .CNT_W(5)) b_if ();

    hit_acc_frame #(.HIT_W(16), .CNT_W(5), .LEN_W(8)) u_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .frame_len (len_b),
        .busy      (busy_b),
        .overflow  (ovf_b),
        .bus       (b_if.slave)
    );

    typedef struct {
        logic [15:0] cand;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   exp_sum;

`ifdef HIT_ACC_SAT_EN
    localparam logic [4:0] OVF_CAND = 5'd31;
`else
    localparam logic [4:0] OVF_CAND = 5'd0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] c, input logic o);
        exp_t e;
        e.cand = c;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    task automatic start_frame_a(input logic [7:0] len);
        len_a   = len;
        start_a = 1'b1;
        exp_sum = 0;
        step();
        start_a = 1'b0;
        len_a   = 8'hAA;    // later changes must not affect the running frame
    endtask

    task automatic beat_a(input logic [15:0] h, input int gap);
        int n;
        a_if.hit_valid = 1'b0;
        for (int i = 0; i < gap; i++) step();
        a_if.hit_valid = 1'b1;
        a_if.hit       = h;
        n = 0;
        while (a_if.hit_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("hit_ready_wait", a_if.hit_ready, 1'b1);
        step();
        exp_sum += $countones(h);
        a_if.hit_valid = 1'b0;
        a_if.hit       = 16'h0;
    endtask

    // Waits for a result, optionally holds back cand_ready while poking start,
    // then completes the handshake and compares against the scoreboard.
    task automatic collect_a(input string tag, input int hold, input bit start_at_hs);
        exp_t e;
        int   n;
        n = 0;
        while (a_if.cand_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid_wait"}, a_if.cand_valid, 1'b1);
        check({tag, "_sb_nonempty"}, (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            for (int i = 0; i < hold; i++) begin
                check({tag, "_hold_cand"}, a_if.candidate, e.cand);
                check({tag, "_hold_ready"}, a_if.hit_ready, 1'b0);
                check({tag, "_hold_busy"}, busy_a, 1'b1);
                start_a = (i == 1);
                len_a   = 8'd1;
                step();
                start_a = 1'b0;
            end
            check({tag, "_cand"}, a_if.candidate, e.cand);
            check({tag, "_ovf"}, ovf_a, e.ovf);
            a_if.cand_ready = 1'b1;
            start_a         = start_at_hs;
            len_a           = 8'd1;
            step();
            a_if.cand_ready = 1'b0;
            start_a         = 1'b0;
            check({tag, "_valid_clr"}, a_if.cand_valid, 1'b0);
            check({tag, "_idle"}, busy_a, 1'b0);
        end
    endtask

    initial begin
        a_if.hit_valid  = 1'b0;
        a_if.hit        = '0;
        a_if.cand_ready = 1'b0;
        b_if.hit_valid  = 1'b0;
        b_if.hit        = '0;
        b_if.cand_ready = 1'b0;
        exp_sum         = 0;

        // Reset state
        rst = 1'b0;
        step();
        step();
        check("rst_cand", a_if.candidate, 16'd0);
        check("rst_cvalid", a_if.cand_valid, 1'b0);
        check("rst_ovf", ovf_a, 1'b0);
        check("rst_hready", a_if.hit_ready, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        rst = 1'b1;
        step();

        // Reset in the middle of a frame
        start_frame_a(8'd4);
        check("acc_hready", a_if.hit_ready, 1'b1);
        check("acc_busy", busy_a, 1'b1);
        beat_a(16'hFFFF, 0);
        beat_a(16'hFFFF, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_cvalid", a_if.cand_valid, 1'b0);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_hready", a_if.hit_ready, 1'b0);
        check("mid_rst_ovf", ovf_a, 1'b0);
        check("mid_rst_cand", a_if.candidate, 16'd0);
        step();
        rst = 1'b1;
        step();
        start_frame_a(8'd1);
        beat_a(16'h0001, 0);
        push_exp(16'd1, 1'b0);
        check("one_beat_latency", a_if.cand_valid, 1'b1);
        collect_a("one_beat", 0, 1'b0);

        // Basic frame, continuous beats
        start_frame_a(8'd3);
        beat_a(16'h000F, 0);
        beat_a(16'h0101, 0);
        check("basic_not_early", a_if.cand_valid, 1'b0);
        beat_a(16'hFFFF, 0);
        check("basic_model", exp_sum, 22);
        push_exp(16'd22, 1'b0);
        check("basic_latency", a_if.cand_valid, 1'b1);
        collect_a("basic", 0, 1'b0);

        // Stalls, backpressure, start in HOLD and on the handshake cycle
        start_frame_a(8'd3);
        beat_a(16'h000F, 2);
        beat_a(16'h0101, 2);
        beat_a(16'hFFFF, 2);
        push_exp(16'd22, 1'b0);
        collect_a("stall", 6, 1'b1);
        step();
        check("hs_start_ignored", busy_a, 1'b0);

        // Back-to-back: start right after the handshake
        push_exp(16'd3, 1'b0);
        start_frame_a(8'd2);
        check("b2b_busy", busy_a, 1'b1);
        beat_a(16'h8000, 0);
        beat_a(16'h0003, 0);
        collect_a("b2b", 0, 1'b0);

        // Zero-length frame with a hit beat pending
        a_if.hit_valid = 1'b1;
        a_if.hit       = 16'hFFFF;
        len_a   = 8'd0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("zero_cvalid", a_if.cand_valid, 1'b1);
        check("zero_hready", a_if.hit_ready, 1'b0);
        push_exp(16'd0, 1'b0);
        collect_a("zero", 0, 1'b0);
        a_if.hit_valid = 1'b0;
        a_if.hit       = 16'h0;
        start_frame_a(8'd1);
        beat_a(16'h0010, 0);
        push_exp(16'd1, 1'b0);
        collect_a("post_zero", 0, 1'b0);
        step();
        check("cand_retained", a_if.candidate, 16'd1);

        // Overflow on the 5-bit instance
        len_b   = 8'd2;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        b_if.hit_valid = 1'b1;
        b_if.hit       = 16'hFFFF;
        step();
        step();
        b_if.hit_valid = 1'b0;
        check("ovf_cvalid", b_if.cand_valid, 1'b1);
        check("ovf_cand", b_if.candidate, OVF_CAND);
        check("ovf_flag", ovf_b, 1'b1);
        b_if.cand_ready = 1'b1;
        step();
        b_if.cand_ready = 1'b0;
        check("ovf_sticky", ovf_b, 1'b1);
        len_b   = 8'd1;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        check("ovf_cleared", ovf_b, 1'b0);
        b_if.hit_valid = 1'b1;
        b_if.hit       = 16'h0003;
        step();
        b_if.hit_valid = 1'b0;
        check("ovf_next_cand", b_if.candidate, 5'd2);
        check("ovf_next_flag", ovf_b, 1'b0);
        b_if.cand_ready = 1'b1;
        step();
        b_if.cand_ready = 1'b0;

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hit_acc_frame.md
Name: hit_acc_frame

Overview:
- Parametrised successor of the team's 4-bit hit accumulator: counts set bits of a HIT_W-wide hit vector over a programmable frame of beats and returns one candidate count per frame.
- Adds frame sequencing, a valid/ready handshake on both hit input and result output, and overflow detection.
- Sits between the hit-generation compare stage and the candidate selection logic.

Parameters:
HIT_W, 16, hit lanes per beat (>=1)
CNT_W, 16, candidate/running-sum width (>= clog2(HIT_W+1))
LEN_W, 8, frame-length field width; max frame = 2^LEN_W-1 beats

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
start  in  1  single-cycle frame start request, honoured only in IDLE
frame_len  in  LEN_W  beats in frame, sampled with accepted start
hit_valid  in  1  hit beat valid
hit  in  HIT_W  hit vector, one bit per lane
hit_ready  out  1  block accepts a beat this cycle
busy  out  1  high in ACC or HOLD
candidate  out  CNT_W  frame result
cand_valid  out  1  candidate valid, held until accepted
cand_ready  in  1  downstream accepts candidate
overflow  out  1  sticky: running sum exceeded CNT_W this frame

Behaviour:
- Reset (rst=0, async): state IDLE; candidate=0, cand_valid=0, overflow=0, hit_ready=0, busy=0; running sum, beat counter cleared. Reset mid-frame aborts the frame; no partial result is emitted.
- States: IDLE, ACC, HOLD.
- IDLE: hit_ready=0, busy=0. start=1 and frame_len!=0 -> latch frame_len, clear sum, beat counter and overflow, go ACC. start=1 and frame_len==0 -> candidate<=0, overflow<=0, cand_valid<=1, go HOLD.
- ACC: hit_ready=1, busy=1. Beat accepted when hit_valid&hit_ready: sum <= sum + popcount(hit); beat counter +1. Cycles with hit_valid=0 leave state unchanged (stall, no timeout).
- Last beat (counter == latched length-1, accepted): candidate <= sum + popcount(hit), cand_valid <= 1 on next edge, go HOLD. Latency: cand_valid high the cycle after the last beat is accepted.
- HOLD: hit_ready=0, busy=1, cand_valid=1, candidate stable. cand_valid&cand_ready -> cand_valid<=0, go IDLE. If cand_ready is already high in the first HOLD cycle, handshake completes that cycle.
- start is ignored in ACC and HOLD, including the HOLD->IDLE cycle. It must be re-presented in IDLE.
- candidate retains its last value after handshake until the next frame result overwrites it.
- Arithmetic: popcount is clog2(HIT_W+1) bits, zero-extended to CNT_W. Sum wraps modulo 2^CNT_W.
- overflow: set on any carry out of CNT_W during the frame; sticky until next accepted start; valid alongside candidate.
- frame_len changes after start acceptance have no effect on the running frame.

Optional Feature:
- Macro: HIT_ACC_SAT_EN.
- Defined: sum saturates at 2^CNT_W-1 instead of wrapping; overflow still sets on the saturating event; candidate = all-ones when saturated.
- Undefined: modulo wrap as above.

Test Plan:
- Reset mid-ACC: HIT_W=16, frame_len=4, 2 beats of 16'hFFFF, then rst=0 -> all outputs 0, IDLE; a new frame of 1 beat 16'h0001 -> candidate=1.
- Basic frame: frame_len=3, beats 16'h000F, 16'h0101, 16'hFFFF with hit_valid continuous, cand_ready=1 -> cand_valid one cycle after beat 3, candidate=22, overflow=0.
- Stalls/backpressure: same frame with hit_valid gaps of 2 cycles and cand_ready held 0 for 5 cycles -> candidate=22, held stable for 5+ cycles, hit_ready=0 in HOLD, start during HOLD ignored.
- Zero-length frame: start with frame_len=0 -> cand_valid next cycle, candidate=0, no hit beats consumed.
- Overflow: CNT_W=5, HIT_W=16, frame_len=2, two beats 16'hFFFF (sum 32) -> without macro candidate=0, overflow=1; with HIT_ACC_SAT_EN candidate=31, overflow=1; next start clears overflow.
- Back-to-back frames: start asserted the cycle after handshake -> second frame accepted. Start asserted in the same cycle as the handshake -> ignored.
